// File: rtl/button_pkg.sv
// Shared constants and types for the push-button input conditioning path.
package button_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 100000;
  localparam int unsigned BTN_WIDTH        = 4;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  typedef logic [BTN_WIDTH-1:0] btn_vec_t;

endpackage

// File: rtl/button_debouncer_channel.sv
// One button bit: two-flop synchroniser, qualification counter, stable level.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic raw_i,
  output logic db_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (en_i) begin
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser shifts every cycle; only the filter state obeys en.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH independent push-button pins into the MHz10 domain.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned WIDTH = BTN_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             MHz10,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] busy
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_i (MHz10),
      .rst_i (rst),
      .en_i  (en),
      .raw_i (btn_raw[i]),
      .db_o  (db_out[i]),
      .busy_o(busy[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed scoreboard bench for button_debouncer with DEBOUNCE_CYCLES = 4.
module tb_button_debouncer;
  import button_pkg::*;

  typedef struct {
    int       sc;
    int       idx;
    btn_vec_t db;
    btn_vec_t busy;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     en = 1'b0;
  btn_vec_t btn_raw = '0;
  btn_vec_t db_out;
  btn_vec_t busy;

  exp_t q[$];
  int   sc = 0;
  int   nvec = 0;
  int   npush = 0;
  int   nbad = 0;

  button_debouncer #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .MHz10  (clk),
    .rst    (rst),
    .en     (en),
    .btn_raw(btn_raw),
    .db_out (db_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Drive before the edge; the expectation is the state after that edge.
  task automatic vec(input logic r, input logic e, input btn_vec_t b,
                     input btn_vec_t xdb, input btn_vec_t xbusy);
    exp_t x;
    @(negedge clk);
    rst = r;
    en = e;
    btn_raw = b;
    x.sc = sc;
    x.idx = npush;
    x.db = xdb;
    x.busy = xbusy;
    q.push_back(x);
    npush++;
  endtask

  task automatic rep(input int n, input logic r, input logic e,
                     input btn_vec_t b, input btn_vec_t xdb,
                     input btn_vec_t xbusy);
    for (int k = 0; k < n; k++) vec(r, e, b, xdb, xbusy);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        nvec++;
        if (db_out !== x.db || busy !== x.busy) begin
          nbad++;
          $display("FAIL sc%0d vec%0d: db_out=%b busy=%b, want db_out=%b busy=%b",
                   x.sc, x.idx, db_out, busy, x.db, x.busy);
        end
      end
    end
  end

  initial begin : stim
    // 1: clean press on channel 0
    sc = 1;
    rep(2, 1, 0, 4'b0000, 4'b0000, 4'b0000);
    vec(0, 1, 4'b0001, 4'b0000, 4'b0000);
    vec(0, 1, 4'b0001, 4'b0000, 4'b0000);
    rep(3, 0, 1, 4'b0001, 4'b0000, 4'b0001);
    vec(0, 1, 4'b0001, 4'b0001, 4'b0000);
    vec(0, 1, 4'b0001, 4'b0001, 4'b0000);

    // 2: bounce on channel 1, then held
    sc = 2;
    rep(2, 0, 1, 4'b0011, 4'b0001, 4'b0000);
    rep(2, 0, 1, 4'b0001, 4'b0001, 4'b0010);
    rep(2, 0, 1, 4'b0011, 4'b0001, 4'b0000);
    rep(2, 0, 1, 4'b0001, 4'b0001, 4'b0010);
    rep(2, 0, 1, 4'b0011, 4'b0001, 4'b0000);
    rep(3, 0, 1, 4'b0011, 4'b0001, 4'b0010);
    rep(2, 0, 1, 4'b0011, 4'b0011, 4'b0000);

    // 3: enable gating on channel 2
    sc = 3;
    rep(2, 0, 1, 4'b0111, 4'b0011, 4'b0000);
    rep(2, 0, 1, 4'b0111, 4'b0011, 4'b0100);
    rep(3, 0, 0, 4'b0111, 4'b0011, 4'b0100);
    vec(0, 1, 4'b0111, 4'b0011, 4'b0100);
    rep(2, 0, 1, 4'b0111, 4'b0111, 4'b0000);

    // 4: press channel 3, reject a 3-cycle low glitch, then release
    sc = 4;
    rep(2, 0, 1, 4'b1111, 4'b0111, 4'b0000);
    rep(3, 0, 1, 4'b1111, 4'b0111, 4'b1000);
    rep(2, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    rep(2, 0, 1, 4'b0111, 4'b1111, 4'b0000);
    vec(0, 1, 4'b0111, 4'b1111, 4'b1000);
    rep(2, 0, 1, 4'b1111, 4'b1111, 4'b1000);
    rep(2, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    rep(2, 0, 1, 4'b0111, 4'b1111, 4'b0000);
    rep(3, 0, 1, 4'b0111, 4'b1111, 4'b1000);
    rep(2, 0, 1, 4'b0111, 4'b0111, 4'b0000);

    // 5: reset mid-count on channel 0
    sc = 5;
    vec(1, 1, 4'b0000, 4'b0000, 4'b0000);
    rep(2, 0, 1, 4'b0001, 4'b0000, 4'b0000);
    rep(2, 0, 1, 4'b0001, 4'b0000, 4'b0001);
    vec(1, 1, 4'b0001, 4'b0000, 4'b0000);
    rep(2, 0, 1, 4'b0001, 4'b0000, 4'b0000);
    rep(3, 0, 1, 4'b0001, 4'b0000, 4'b0001);
    rep(2, 0, 1, 4'b0001, 4'b0001, 4'b0000);

    // 6: all channels together
    sc = 6;
    vec(1, 1, 4'b0000, 4'b0000, 4'b0000);
    rep(2, 0, 1, 4'b1111, 4'b0000, 4'b0000);
    rep(3, 0, 1, 4'b1111, 4'b0000, 4'b1111);
    rep(2, 0, 1, 4'b1111, 4'b1111, 4'b0000);

    repeat (3) @(posedge clk);
    #2;
    nvec++;
    if (q.size() != 0 || nvec != npush + 1) begin
      nbad++;
      $display("FAIL drain: %0d left in queue, %0d checked, want 0 left and %0d checked",
               q.size(), nvec - 1, npush);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
